// File: rtl/chaos_lfsr_mixer.sv
// Keystream generator: a 16-bit Fibonacci LFSR that periodically folds in a
// chaotic-map sample, with a valid/ready handshake on the keystream output.
module chaos_lfsr_mixer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] lfsr_seed,
    input  logic [7:0]  reseed_period,
    input  logic [15:0] chaos_in,
    input  logic        chaos_valid,
    output logic        chaos_ready,
    output logic [15:0] key_out,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        MIX  = 2'd3
    } state_t;

    // Substituted whenever a seed or a mix would leave the LFSR in its lock-up state.
    localparam logic [15:0] SAFE_SEED = 16'hACE1;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [7:0]  cnt;
    logic [15:0] lfsr_stepped;
    logic [15:0] lfsr_mixed;
    logic        adv;
    logic        period_hit;

    always_comb begin
        lfsr_stepped = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        lfsr_mixed   = lfsr ^ chaos_in;
        adv          = (state == RUN) && (!key_valid || key_ready);
        period_hit   = (reseed_period != 8'd0) && (cnt == reseed_period - 8'd1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (adv && period_hit) state_next = MIX;
            MIX:  if (chaos_valid) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (stop) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Stop only retires the pending word; the LFSR keeps its value until the next LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= 16'd0;
            cnt       <= 8'd0;
            key_out   <= 16'd0;
            key_valid <= 1'b0;
        end else if (stop) begin
            key_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    lfsr <= (lfsr_seed == 16'd0) ? SAFE_SEED : lfsr_seed;
                    cnt  <= 8'd0;
                end
                RUN: begin
                    if (adv) begin
                        lfsr      <= lfsr_stepped;
                        key_out   <= lfsr_stepped;
                        key_valid <= 1'b1;
                        cnt       <= cnt + 8'd1;
                    end
                end
                MIX: begin
                    if (key_ready) key_valid <= 1'b0;
                    if (chaos_valid) begin
                        lfsr <= (lfsr_mixed == 16'd0) ? SAFE_SEED : lfsr_mixed;
                        cnt  <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign chaos_ready = (state == MIX);
    assign busy        = (state != IDLE);

endmodule
